// File: rtl/frame_dump_pkg.sv
// Shared types for the frame-window capture scheduler.
package frame_dump_pkg;
  localparam int CNTW_DEF = 32;
  localparam int LENW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_DL    = 3'd1,
    WAIT_START = 3'd2,
    CAPTURE    = 3'd3,
    DONE       = 3'd4
  } state_e;
endpackage

// File: rtl/frame_edge_cnt.sv
// Vsync falling-edge detect and download-gated frame counter.
module frame_edge_cnt
  import frame_dump_pkg::*;
#(
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vs,
  input  logic            downloading,
  output logic            fe,
  output logic [CNTW-1:0] frame_cnt
);

  logic            vs_q;
  logic            fe_q;
  logic            fe_d;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  assign fe_d = vs_q & ~vs;

  always_comb begin
    cnt_d = cnt_q;
    if (downloading) begin
      cnt_d = '0;
    end else if (fe_q) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q  <= 1'b1;
      fe_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      vs_q  <= vs;
      fe_q  <= fe_d;
      cnt_q <= cnt_d;
    end
  end

  assign fe        = fe_q;
  assign frame_cnt = cnt_q;

endmodule

// File: rtl/frame_dump_sched.sv
// Capture-window scheduler: waits for download end and start frame,
// then issues one snapshot request per frame until len frames are acked.
module frame_dump_sched
  import frame_dump_pkg::*;
#(
  parameter int CNTW = CNTW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vs,
  input  logic            downloading,
  input  logic [CNTW-1:0] cfg_start,
  input  logic [LENW-1:0] cfg_len,
  input  logic            arm,
  input  logic            abort,
  output logic [CNTW-1:0] frame_cnt,
  output logic            dump_on,
  output logic            snap_req,
  input  logic            snap_ack,
  output logic            done,
  output logic            overrun,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [CNTW-1:0] start_q, start_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic            dump_q, dump_d;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            fe;
  logic [CNTW-1:0] cnt_inc;
  logic            ack_ok;

  frame_edge_cnt #(
    .CNTW(CNTW)
  ) u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .vs         (vs),
    .downloading(downloading),
    .fe         (fe),
    .frame_cnt  (frame_cnt)
  );

  // Compare against the value the counter takes on this same edge.
  assign cnt_inc = frame_cnt + CNTW'(1);
  assign ack_ok  = snap_ack & req_q;

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    len_d   = len_q;
    rem_d   = rem_q;
    dump_d  = dump_q;
    req_d   = req_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    if (abort) begin
      state_d = IDLE;
      dump_d  = 1'b0;
      req_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            start_d = cfg_start;
            len_d   = cfg_len;
            done_d  = 1'b0;
            ovr_d   = 1'b0;
            state_d = WAIT_DL;
          end
        end
        WAIT_DL: begin
          if (!downloading) state_d = WAIT_START;
        end
        WAIT_START: begin
          if (downloading) begin
            state_d = WAIT_DL;
          end else if (fe && cnt_inc == start_q) begin
            if (len_q == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = CAPTURE;
              rem_d   = len_q;
              dump_d  = 1'b1;
              req_d   = 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (downloading) begin
            state_d = WAIT_DL;
            dump_d  = 1'b0;
            req_d   = 1'b0;
          end else if (ack_ok && rem_q == LENW'(1)) begin
            state_d = DONE;
            rem_d   = '0;
            dump_d  = 1'b0;
            req_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (ack_ok) begin
              rem_d = rem_q - LENW'(1);
              req_d = 1'b0;
            end
            // An unacked request at a new frame is flagged, not re-issued.
            if (fe) begin
              if (req_q && !ack_ok) ovr_d = 1'b1;
              req_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      dump_q  <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      dump_q  <= dump_d;
      req_q   <= req_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dump_on  = dump_q;
  assign snap_req = req_q;
  assign done     = done_q;
  assign overrun  = ovr_q;
  assign busy     = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_frame_dump_sched.sv
// Directed bench for frame_dump_sched: vector table plus corner sequences.
module tb_frame_dump_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b1;
  logic        downloading = 1'b1;
  logic [31:0] cfg_start = '0;
  logic [15:0] cfg_len = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        snap_ack = 1'b0;
  logic [31:0] frame_cnt;
  logic        dump_on;
  logic        snap_req;
  logic        done;
  logic        overrun;
  logic        busy;

  int total = 0;
  int bad = 0;

  frame_dump_sched #(
    .CNTW(32),
    .LENW(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vs         (vs),
    .downloading(downloading),
    .cfg_start  (cfg_start),
    .cfg_len    (cfg_len),
    .arm        (arm),
    .abort      (abort),
    .frame_cnt  (frame_cnt),
    .dump_on    (dump_on),
    .snap_req   (snap_req),
    .snap_ack   (snap_ack),
    .done       (done),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vs;
    logic        dl;
    logic        arm;
    logic [31:0] st;
    logic [15:0] ln;
    logic [31:0] cnt;
    logic        dump;
    logic        req;
    logic        done;
    logic        ovr;
    logic        busy;
  } vec_t;

  vec_t tv[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic frame();
    vs = 1'b0;
    tick();
    vs = 1'b1;
    tick();
  endtask

  task automatic ack();
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] c,
                         input logic d, input logic r, input logic dn,
                         input logic o, input logic b);
    chk({tag, ".cnt"}, frame_cnt, c);
    chk({tag, ".dump"}, 32'(dump_on), 32'(d));
    chk({tag, ".req"}, 32'(snap_req), 32'(r));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".ovr"}, 32'(overrun), 32'(o));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    //          vs  dl  arm st ln   cnt dump req done ovr busy
    tv[0]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 2, 0, 0, 0, 0, 0, 0, 1};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0, 1};
    tv[10] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0, 1};
    tv[11] = '{1'b1, 1'b0, 1'b0, 0, 0, 2, 0, 0, 1, 0, 0};
    tv[12] = '{1'b1, 1'b0, 1'b0, 0, 0, 2, 0, 0, 1, 0, 0};

    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Download frames, then len=0 start=2 sequence.
    for (int i = 0; i < 13; i++) begin
      vs        = tv[i].vs;
      downloading = tv[i].dl;
      arm       = tv[i].arm;
      cfg_start = tv[i].st;
      cfg_len   = tv[i].ln;
      tick();
      arm = 1'b0;
      chk_all($sformatf("vec%0d", i), tv[i].cnt, tv[i].dump, tv[i].req,
              tv[i].done, tv[i].ovr, tv[i].busy);
    end

    // Normal capture: start=5 len=3, ack 10 cycles after each request.
    cfg_start = 5;
    cfg_len   = 3;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("b.armdone", 32'(done), 0);
    chk("b.armbusy", 32'(busy), 1);
    tick();
    frame();
    frame();
    chk("b.predump", 32'(dump_on), 0);
    chk("b.cnt4", frame_cnt, 4);
    frame();
    chk_all("b.open", 5, 1, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      repeat (9) tick();
      chk($sformatf("b.held%0d", k), 32'(snap_req), 1);
      ack();
      chk($sformatf("b.reqlo%0d", k), 32'(snap_req), 0);
      if (k < 2) begin
        chk($sformatf("b.dumpon%0d", k), 32'(dump_on), 1);
        if (k == 0) ack();
        frame();
        chk($sformatf("b.reqhi%0d", k), 32'(snap_req), 1);
      end
    end
    chk_all("b.end", 7, 0, 0, 1, 0, 0);

    // Overrun: first request left unacked across a frame edge.
    cfg_start = 9;
    cfg_len   = 3;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    frame();
    frame();
    chk_all("c.open", 9, 1, 1, 0, 0, 1);
    frame();
    chk_all("c.ovr", 10, 1, 1, 0, 1, 1);
    ack();
    chk("c.req0", 32'(snap_req), 0);
    frame();
    ack();
    frame();
    chk("c.dump2", 32'(dump_on), 1);
    ack();
    chk_all("c.end", 12, 0, 0, 1, 1, 0);

    // Abort with simultaneous arm during capture.
    cfg_start = 14;
    cfg_len   = 4;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    frame();
    frame();
    chk_all("d.open", 14, 1, 1, 0, 0, 1);
    abort = 1'b1;
    arm   = 1'b1;
    cfg_start = 20;
    tick();
    abort = 1'b0;
    arm   = 1'b0;
    chk_all("d.abort", 14, 0, 0, 0, 0, 0);
    tick();
    chk("d.noarm", 32'(busy), 0);

    // Counter wrap triggers start=0, then download returns mid-capture.
    cfg_start = 0;
    cfg_len   = 2;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    force dut.u_edge.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_edge.cnt_q;
    #1;
    chk("e.preset", frame_cnt, 32'hFFFF_FFFE);
    frame();
    chk_all("e.max", 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
    frame();
    chk_all("e.wrap", 0, 1, 1, 0, 0, 1);
    ack();
    frame();
    chk_all("e.cnt1", 1, 1, 1, 0, 0, 1);
    downloading = 1'b1;
    tick();
    chk_all("e.redl", 0, 0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a capture window.
    downloading = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cfg_start = 2;
    cfg_len   = 2;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    frame();
    frame();
    chk_all("f.open", 2, 1, 1, 0, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("f.rst", 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_dump_sched.md
Name: frame_dump_sched

Overview:
Frame-window capture scheduler for simulation and on-board debug of the game cores.
- Counts video frames on the falling edge of vertical sync.
- Holds off while the ROM download is in progress.
- Opens a capture window of a programmed length at a programmed start frame.
- During the window, issues one snapshot request per frame to a capture/readout agent through a req/ack handshake.
- Sits beside the game top, between the video timing outputs and the dump/readout logic, and drives its enable.

Parameters:
CNTW, 32, frame counter width
LENW, 16, capture-length width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
vs  in  1  vertical sync (VGA_VS), already synchronous to clk; a frame edge is a 1→0 transition
downloading  in  1  ROM download in progress (led); high = loading
cfg_start  in  CNTW  first frame number to capture
cfg_len  in  LENW  number of frames to capture
arm  in  1  one-cycle pulse that latches cfg_start/cfg_len and starts a sequence
abort  in  1  one-cycle pulse that ends any sequence
frame_cnt  out  CNTW  frames counted since the end of download
dump_on  out  1  high for the whole capture window
snap_req  out  1  snapshot request, one per captured frame
snap_ack  in  1  snapshot accepted; single-cycle pulse
done  out  1  sequence completed normally (sticky until next arm)
overrun  out  1  a snapshot was not acknowledged before the next frame edge (sticky until next arm)
busy  out  1  state is not IDLE or DONE

Behaviour:
- Reset: frame_cnt=0, dump_on=0, snap_req=0, done=0, overrun=0, busy=0, state=IDLE, vs_q=1.
- Frame edge fe = vs_q & ~vs. It is registered, so fe is asserted one cycle after vs falls.
- frame_cnt:
  - Held at 0 while downloading=1.
  - Otherwise increments on fe.
  - Wraps from 2^CNTW-1 to 0.
- States: IDLE, WAIT_DL, WAIT_START, CAPTURE, DONE.
- IDLE: on arm, latch start_r and len_r, clear done and overrun, then go to WAIT_DL.
- WAIT_DL:
  - If downloading=1, stay.
  - Otherwise go to WAIT_START next cycle.
  - If downloading rises again in WAIT_START or CAPTURE, return to WAIT_DL and drop dump_on/snap_req. No done is raised.
- WAIT_START:
  - When fe occurs and the incremented frame_cnt == start_r, go to CAPTURE. Load remaining = len_r and set dump_on=1 in that same cycle.
  - If len_r==0, go straight to DONE with done=1 and dump_on never asserted.
  - If start_r==0: capture begins at the first fe whose wrapped count equals 0. It is not immediate.
- CAPTURE:
  - On each fe, if snap_req is still high, set overrun=1 and keep snap_req high (no re-issue). Otherwise set snap_req=1.
  - snap_req clears in the cycle after snap_ack. snap_ack with snap_req low is ignored.
  - The first snap_req is raised on the cycle CAPTURE is entered.
  - remaining decrements when snap_ack is accepted.
  - When remaining reaches 0, go to DONE: dump_on=0, snap_req=0, done=1.
- DONE: busy=0. On arm, restart as from IDLE.
- abort in any state: next cycle state=IDLE, dump_on=0, snap_req=0. done and overrun are kept. If abort and arm occur in the same cycle, abort wins.
- arm while busy is ignored.
- Asynchronous reset mid-capture: every output returns to its reset value immediately.
- Latency: fe to dump_on/snap_req is 1 cycle; snap_ack to snap_req low is 1 cycle.

Decomposition:
- Shared package frame_dump_pkg holds:
  - the state enum (IDLE=0, WAIT_DL=1, WAIT_START=2, CAPTURE=3, DONE=4), 3 bits;
  - default CNTW and LENW.
- One sub-module, frame_edge_cnt: vs edge detect plus the download-gated, wrapping frame counter, with outputs fe and frame_cnt. The FSM stays in the top module.

Test Plan:
- Reset then 3 frames with downloading=1 → frame_cnt=0 throughout; outputs at reset values.
- downloading 1→0, arm cfg_start=5, cfg_len=3, ack 10 cycles after each req → dump_on rises 1 cycle after the fe giving frame_cnt=5; 3 snap_req pulses; dump_on falls on the 3rd ack; done=1, overrun=0.
- Same configuration with snap_ack withheld across a frame edge → overrun=1, only one outstanding req, capture still completes after 3 acks.
- arm with cfg_len=0, cfg_start=2 → done=1 after the frame-2 edge; dump_on never high.
- abort mid-CAPTURE, with arm in the same cycle → state IDLE, dump_on=0, done stays 0; the arm is ignored.
- frame_cnt preset near 2^32-1 (force), cfg_start=0 → wrap to 0 triggers capture; downloading re-asserted mid-capture → WAIT_DL, dump_on=0, frame_cnt=0.
